// File: rtl/adder_err_accum.sv
// adder_err_accum: exhaustive error-metric engine for a combinational
// approximate adder. Sweeps every {a,b} operand pair, compares the adder's
// result against the exact sum and accumulates count/sum/abs/square metrics.
//
// Ports:
//   clk            in   clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   start          in   sweep request, honoured in IDLE or DONE only
//   a_out, b_out   out  operands driven to the adder under test (0 outside SWEEP)
//   approx_sum_in  in   adder result, combinational from a_out/b_out
//   busy           out  high while sweeping or draining
//   done           out  high in DONE, results valid and stable
//   total_cases    out  number of cases accumulated
//   error_count    out  cases with a nonzero error
//   error_sum      out  signed sum of (approx - exact)
//   abs_error_sum  out  sum of |approx - exact|
//   sq_error_sum   out  sum of (approx - exact)^2
module adder_err_accum #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic [WIDTH-1:0]          a_out,
  output logic [WIDTH-1:0]          b_out,
  input  logic [WIDTH:0]            approx_sum_in,
  output logic                      busy,
  output logic                      done,
  output logic [2*WIDTH:0]          total_cases,
  output logic [2*WIDTH:0]          error_count,
  output logic signed [3*WIDTH+1:0] error_sum,
  output logic [3*WIDTH:0]          abs_error_sum,
  output logic [4*WIDTH+1:0]        sq_error_sum
);

  localparam int unsigned CW  = 2 * WIDTH;      // operand counter {a,b}
  localparam int unsigned SW  = WIDTH + 1;      // exact sum
  localparam int unsigned EW  = WIDTH + 2;      // signed error
  localparam int unsigned AW  = WIDTH + 1;      // |error|
  localparam int unsigned PW  = 2 * WIDTH + 2;  // |error|^2
  localparam int unsigned TW  = 2 * WIDTH + 1;  // case counters
  localparam int unsigned ESW = 3 * WIDTH + 2;  // signed error sum
  localparam int unsigned ASW = 3 * WIDTH + 1;  // absolute error sum
  localparam int unsigned QW  = 4 * WIDTH + 2;  // squared error sum

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Control state
  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                drain_q, drain_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                clear_c;

  // Pipeline stage 1
  logic                valid1_q, valid1_d;
  logic signed [EW-1:0] err_q, err_d;
  logic [SW-1:0]       exact_c;

  // Pipeline stage 2 (accumulators)
  logic [AW-1:0]       abs_c;
  logic [PW-1:0]       sq_c;
  logic [TW-1:0]       total_q, total_d;
  logic [TW-1:0]       errcnt_q, errcnt_d;
  logic signed [ESW-1:0] esum_q, esum_d;
  logic [ASW-1:0]      asum_q, asum_d;
  logic [QW-1:0]       qsum_q, qsum_d;

  // Next-state and sweep control
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    clear_c = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_SWEEP;
          cnt_d   = '0;
          clear_c = 1'b1;
        end
      end
      S_SWEEP: begin
        // b is the low half, so it increments fastest and carries into a;
        // the all-ones pair wraps the counter back to zero.
        cnt_d   = cnt_q + CW'(1);
        drain_d = 1'b0;
        if (cnt_q == '1) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d == S_SWEEP) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  // Stage 1: exact sum and signed error of the pair on the bus this cycle
  always_comb begin
    exact_c  = SW'(a_out) + SW'(b_out);
    valid1_d = (state_q == S_SWEEP);
    err_d    = '0;
    if (valid1_d) begin
      err_d = $signed(EW'(approx_sum_in)) - $signed(EW'(exact_c));
    end
  end

  // Stage 2: metric updates; acceptance of a new sweep clears everything
  always_comb begin
    abs_c    = AW'(err_q[EW-1] ? -err_q : err_q);
    sq_c     = PW'(abs_c) * PW'(abs_c);
    total_d  = total_q;
    errcnt_d = errcnt_q;
    esum_d   = esum_q;
    asum_d   = asum_q;
    qsum_d   = qsum_q;
    if (clear_c) begin
      total_d  = '0;
      errcnt_d = '0;
      esum_d   = '0;
      asum_d   = '0;
      qsum_d   = '0;
    end else if (valid1_q) begin
      total_d  = total_q + TW'(1);
      errcnt_d = errcnt_q + TW'(err_q != '0);
      esum_d   = esum_q + ESW'(err_q);
      asum_d   = asum_q + ASW'(abs_c);
      qsum_d   = qsum_q + QW'(sq_c);
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      drain_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid1_q <= 1'b0;
      err_q    <= '0;
      total_q  <= '0;
      errcnt_q <= '0;
      esum_q   <= '0;
      asum_q   <= '0;
      qsum_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      drain_q  <= drain_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      valid1_q <= valid1_d;
      err_q    <= err_d;
      total_q  <= total_d;
      errcnt_q <= errcnt_d;
      esum_q   <= esum_d;
      asum_q   <= asum_d;
      qsum_q   <= qsum_d;
    end
  end

  assign a_out         = cnt_q[CW-1:WIDTH];
  assign b_out         = cnt_q[WIDTH-1:0];
  assign busy          = busy_q;
  assign done          = done_q;
  assign total_cases   = total_q;
  assign error_count   = errcnt_q;
  assign error_sum     = esum_q;
  assign abs_error_sum = asum_q;
  assign sq_error_sum  = qsum_q;

endmodule

// File: tb/tb_adder_err_accum.sv
// Directed bench for adder_err_accum: a WIDTH=8 instance with an exact-adder
// stub runs one full sweep while a WIDTH=2 instance with a selectable stub
// goes through the short directed scenarios.
module tb_adder_err_accum;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  // WIDTH=8 instance, exact adder stub
  logic        rst8_n, start8;
  logic [7:0]  a8, b8;
  logic [8:0]  approx8;
  logic        busy8, done8;
  logic [16:0] total8, count8;
  logic signed [25:0] esum8;
  logic [24:0] asum8;
  logic [33:0] qsum8;

  assign approx8 = 9'(a8) + 9'(b8);

  adder_err_accum #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst8_n), .start(start8),
    .a_out(a8), .b_out(b8), .approx_sum_in(approx8),
    .busy(busy8), .done(done8),
    .total_cases(total8), .error_count(count8), .error_sum(esum8),
    .abs_error_sum(asum8), .sq_error_sum(qsum8)
  );

  // WIDTH=2 instance, stub selected by mode: 0 -> zero, 1 -> exact, 2 -> exact+1
  logic        rst2_n, start2;
  logic [1:0]  mode;
  logic [1:0]  a2, b2;
  logic [2:0]  approx2;
  logic        busy2, done2;
  logic [4:0]  total2, count2;
  logic signed [7:0] esum2;
  logic [6:0]  asum2;
  logic [9:0]  qsum2;

  always_comb begin
    case (mode)
      2'd0:    approx2 = 3'd0;
      2'd1:    approx2 = 3'(a2) + 3'(b2);
      default: approx2 = 3'(a2) + 3'(b2) + 3'd1;
    endcase
  end

  adder_err_accum #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst2_n), .start(start2),
    .a_out(a2), .b_out(b2), .approx_sum_in(approx2),
    .busy(busy2), .done(done2),
    .total_cases(total2), .error_count(count2), .error_sum(esum2),
    .abs_error_sum(asum2), .sq_error_sum(qsum2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse start2 for one edge; returns the cycle index of the accepting edge.
  task automatic pulse_start2(output int k);
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    k = cyc;
  endtask

  // Wait (bounded) for done2 and check start-to-done latency.
  task automatic wait_done2(input int k, input string tag);
    int i = 0;
    while (!done2 && i < 100) begin
      @(negedge clk);
      i++;
    end
    check({tag, "_latency"}, 64'(cyc - k), 64'd18);
    check({tag, "_busy_at_done"}, 64'(busy2), 64'd0);
  endtask

  task automatic check_res2(input string tag, input int t, input int c,
                            input int e, input int a, input int q);
    check({tag, "_total"}, 64'(total2), 64'(t));
    check({tag, "_count"}, 64'(count2), 64'(c));
    check({tag, "_esum"},  64'(esum2),  64'(e));
    check({tag, "_asum"},  64'(asum2),  64'(a));
    check({tag, "_qsum"},  64'(qsum2),  64'(q));
  endtask

  initial begin
    int k8;
    int k;
    int i;
    rst8_n = 1'b0;
    rst2_n = 1'b0;
    start8 = 1'b0;
    start2 = 1'b0;
    mode   = 2'd0;
    repeat (2) @(negedge clk);

    // Reset values
    check("rst8_a", 64'(a8), 64'd0);
    check("rst8_b", 64'(b8), 64'd0);
    check("rst8_busy", 64'(busy8), 64'd0);
    check("rst8_done", 64'(done8), 64'd0);
    check("rst8_total", 64'(total8), 64'd0);
    check("rst8_qsum", 64'(qsum8), 64'd0);
    check("rst2_busy", 64'(busy2), 64'd0);
    check("rst2_done", 64'(done2), 64'd0);
    check("rst2_total", 64'(total2), 64'd0);
    rst8_n = 1'b1;
    rst2_n = 1'b1;
    @(negedge clk);
    check("idle2_busy", 64'(busy2), 64'd0);

    // Long WIDTH=8 sweep runs in the background of the WIDTH=2 scenarios
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    k8 = cyc;
    check("w8_busy_after_start", 64'(busy8), 64'd1);

    // WIDTH=2, approx=0: operand sequence and metrics
    mode = 2'd0;
    pulse_start2(k);
    for (int n = 0; n < 16; n++) begin
      check($sformatf("seq_a%0d", n), 64'(a2), 64'(n / 4));
      check($sformatf("seq_b%0d", n), 64'(b2), 64'(n % 4));
      check($sformatf("seq_busy%0d", n), 64'(busy2), 64'd1);
      @(negedge clk);
    end
    check("drain_a", 64'(a2), 64'd0);
    check("drain_b", 64'(b2), 64'd0);
    check("drain_busy", 64'(busy2), 64'd1);
    check("drain_done", 64'(done2), 64'd0);
    wait_done2(k, "zero");
    check_res2("zero", 16, 15, -48, 48, 184);
    check("done_a", 64'(a2), 64'd0);

    // WIDTH=2, approx=exact+1
    mode = 2'd2;
    pulse_start2(k);
    wait_done2(k, "plus1");
    check_res2("plus1", 16, 16, 16, 16, 16);

    // WIDTH=2, extra start pulses during SWEEP and DRAIN are ignored
    mode = 2'd0;
    pulse_start2(k);
    repeat (3) @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    repeat (12) @(negedge clk);
    check("restart_in_drain_busy", 64'(busy2), 64'd1);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    wait_done2(k, "restart");
    check_res2("restart", 16, 15, -48, 48, 184);

    // WIDTH=2, asynchronous reset mid-sweep
    pulse_start2(k);
    repeat (6) @(negedge clk);
    check("pre_rst_total_nonzero", 64'(total2 != 5'd0), 64'd1);
    #2 rst2_n = 1'b0;
    #1;
    check("arst_a", 64'(a2), 64'd0);
    check("arst_b", 64'(b2), 64'd0);
    check("arst_busy", 64'(busy2), 64'd0);
    check("arst_done", 64'(done2), 64'd0);
    check_res2("arst", 0, 0, 0, 0, 0);
    #1 rst2_n = 1'b1;
    pulse_start2(k);
    wait_done2(k, "after_rst");
    check_res2("after_rst", 16, 15, -48, 48, 184);

    // WIDTH=2, start accepted from DONE clears results; now exact stub
    mode = 2'd1;
    pulse_start2(k);
    check("redo_done_cleared", 64'(done2), 64'd0);
    check("redo_busy", 64'(busy2), 64'd1);
    check_res2("redo_cleared", 0, 0, 0, 0, 0);
    wait_done2(k, "redo");
    check_res2("redo", 16, 0, 0, 0, 0);

    // WIDTH=2, start held: done lasts one cycle, then a new sweep begins
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    k = cyc;
    check("held_busy", 64'(busy2), 64'd1);
    i = 0;
    while (!done2 && i < 100) begin
      @(negedge clk);
      i++;
    end
    check("held_latency", 64'(cyc - k), 64'd18);
    @(negedge clk);
    check("held_done_one_cycle", 64'(done2), 64'd0);
    check("held_resweep_busy", 64'(busy2), 64'd1);
    start2 = 1'b0;

    // WIDTH=8 full sweep with exact stub
    i = 0;
    while (!done8 && i < 70000) begin
      @(negedge clk);
      i++;
    end
    check("w8_latency", 64'(cyc - k8), 64'd65538);
    check("w8_busy", 64'(busy8), 64'd0);
    check("w8_total", 64'(total8), 64'd65536);
    check("w8_count", 64'(count8), 64'd0);
    check("w8_esum", 64'(esum8), 64'd0);
    check("w8_asum", 64'(asum8), 64'd0);
    check("w8_qsum", 64'(qsum8), 64'd0);
    check("w8_a_done", 64'(a8), 64'd0);
    @(negedge clk);
    check("w8_done_held", 64'(done8), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/adder_err_accum.md
# adder_err_accum

Synthesizable error-metric engine for approximate adders. It sweeps every operand pair of a WIDTH-bit adder and drives it into an external combinational approximate adder under test (the LOA and its siblings). It computes the exact sum internally and accumulates error count, signed error sum, absolute error sum and squared error sum. It sits directly upstream of the adder (stimulus) and directly downstream of it (result consumer), replacing simulation-only metric collection with an on-chip or emulation-friendly datapath.

## Interface
- WIDTH, 8, operand width of the adder under test; N = 2^(2·WIDTH) cases per sweep
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  sweep request, sampled only in IDLE or DONE
- a_out  out  WIDTH  operand a to the adder under test
- b_out  out  WIDTH  operand b to the adder under test
- approx_sum_in  in  WIDTH+1  adder output, combinational from a_out/b_out
- busy  out  1  high in SWEEP and DRAIN
- done  out  1  high in DONE; results valid and stable
- total_cases  out  2·WIDTH+1  cases accumulated
- error_count  out  2·WIDTH+1  cases with nonzero error
- error_sum  out  3·WIDTH+2 signed  Σ(approx − exact)
- abs_error_sum  out  3·WIDTH+1  Σ|approx − exact|
- sq_error_sum  out  4·WIDTH+2  Σ(approx − exact)²

## Operation
- States: IDLE, SWEEP, DRAIN, DONE. Reset enters IDLE.
- IDLE/DONE + start=1 → SWEEP:
  - operand counter {a_out,b_out} cleared to 0
  - all accumulators and total_cases cleared
  - done cleared
- SWEEP:
  - One pair is presented per cycle. b_out increments fastest; a_out increments when b_out wraps from all-ones to 0.
  - The cycle presenting a=all-ones, b=all-ones is the last one. The counter then wraps to 0 and the state moves to DRAIN.
- DRAIN: 2 cycles to flush the pipeline, then DONE.
- DONE: outputs held until the next start or reset. a_out/b_out are 0 outside SWEEP.
- start in SWEEP or DRAIN is ignored with no effect.
- Pipeline stage 1, registered:
  - exact = a_out + b_out, computed at WIDTH+1 bits
  - err = approx_sum_in − exact, as a signed WIDTH+2-bit value
  - valid1 is set for every SWEEP cycle
- Pipeline stage 2, registered, when valid1=1:
  - total_cases += 1
  - error_count += (err≠0)
  - error_sum += sign-extended err
  - abs_error_sum += |err|
  - sq_error_sum += err·err
- Width rules: all widths are sized for the worst case over N cases, so no accumulator may overflow or wrap. The square is computed as an unsigned (WIDTH+1)×(WIDTH+1) product of |err|.

## Timing
- Reset values: a_out, b_out, busy, done, and all result outputs 0; valid1 0; state IDLE.
- Reset mid-sweep or mid-drain: immediate return to IDLE, all cleared, no done pulse.
- Sweep timeline, with start accepted at edge k:
  - busy=1 from edge k.
  - Pair n (n = 0…N−1) is presented in the cycle after edge k+n.
  - Its error is captured at k+n+1 and accumulated at k+n+2.
  - State is DRAIN after edge k+N.
  - At edge k+N+2: done=1, busy=0.
- Start-to-done latency: N+2 cycles (65538 for WIDTH=8).
- approx_sum_in must settle within the same cycle as a_out/b_out. A registered adder under test is not supported.
- start=1 held continuously: one sweep per acceptance. A new sweep starts on the first cycle in DONE, and done is high for exactly that cycle.

## Test plan
- WIDTH=8, stub approx_sum_in=a_out+b_out, pulse start:
  - done high exactly 65538 cycles after start
  - total_cases=65536
  - error_count, error_sum, abs_error_sum and sq_error_sum all 0
- WIDTH=2, stub approx_sum_in=0:
  - total_cases=16
  - error_count=15
  - error_sum=−48
  - abs_error_sum=48
  - sq_error_sum=184
  - a_out/b_out sequence 0/0, 0/1, 0/2, 0/3, 1/0, …, 3/3
- WIDTH=2, stub approx_sum_in=a_out+b_out+1: total_cases=16, error_count=16, error_sum=16, abs_error_sum=16, sq_error_sum=16.
- WIDTH=2, start pulsed again during SWEEP and DRAIN: ignored; results identical to the single-start run; done at cycle 18.
- WIDTH=2, rst_n low mid-SWEEP at cycle 7: all outputs 0 asynchronously. A new start yields the full 16-case results, not a partial accumulation.
- WIDTH=2, start asserted in DONE after a run with approx=0, stub switched to the exact adder: accumulators cleared on acceptance; final results all-zero errors with total_cases=16.
